// File: rtl/inst_decode_queue_if.sv
// rtl/inst_decode_queue_if.sv - fetch/execute handshake and decoded-field bundle for inst_decode_queue
interface inst_decode_queue_if #(
   parameter int W     = 32,
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [W-1:0]             in_inst;
   logic [W-1:0]             in_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [W-1:0]             out_pc;
   logic [1:0]               inst_type;
   logic [5:0]               op_code;
   logic [5:0]               funct;
   logic [4:0]               rs;
   logic [4:0]               rt;
   logic [4:0]               rd;
   logic [4:0]               shamt;
   logic [W-1:0]             imm;
   logic                     illegal;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, inst_type, op_code, funct,
             rs, rt, rd, shamt, imm, illegal, count
   );

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, inst_type, op_code, funct,
             rs, rt, rd, shamt, imm, illegal, count
   );
endinterface

// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - instruction FIFO with registered MIPS-style decode stage
// Optional feature: define ID_ILLEGAL_DET_EN to enable unsupported-encoding detection on illegal.
module inst_decode_queue #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   input logic               flush,
   inst_decode_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]  DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [W-1:0] J_MASK  = ~W'(32'h0FFF_FFFF);

   logic [W-1:0]  inst_mem [DEPTH];
   logic [W-1:0]  pc_mem   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic          push;
   logic          pop;

   logic [W-1:0]  h_inst;
   logic [W-1:0]  h_pc;
   logic [W-1:0]  pc_plus4;
   logic [5:0]    d_op;
   logic [5:0]    d_funct;
   logic [1:0]    d_type;
   logic [W-1:0]  d_imm;
`ifdef ID_ILLEGAL_DET_EN
   logic          d_known;
`endif

   // in_ready depends only on registered occupancy, never on out_ready
   assign bus.in_ready = (count_q < DEPTH_C);
   assign bus.count    = count_q;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = (count_q != '0) && (!bus.out_valid || bus.out_ready);

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) begin
         inst_mem[wr_ptr] <= bus.in_inst;
         pc_mem[wr_ptr]   <= bus.in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign h_inst   = inst_mem[rd_ptr];
   assign h_pc     = pc_mem[rd_ptr];
   assign pc_plus4 = h_pc + W'(4);
   assign d_op     = h_inst[31:26];
   assign d_funct  = h_inst[5:0];

   always_comb begin
      d_type = 2'd1;
      d_imm  = '0;
`ifdef ID_ILLEGAL_DET_EN
      d_known = 1'b1;
`endif
      case (d_op)
         6'h00: begin
            d_type = 2'd0;
            if (d_funct == 6'h00 || d_funct == 6'h02 || d_funct == 6'h03)
               d_imm = W'(h_inst[10:6]);
`ifdef ID_ILLEGAL_DET_EN
            case (d_funct)
               6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B: d_known = 1'b1;
               default:      d_known = 1'b0;
            endcase
`endif
         end
         6'h02, 6'h03: begin
            // Absolute jump target keeps the top nibble of the sequential PC
            d_type = 2'd2;
            d_imm  = (pc_plus4 & J_MASK) | W'({h_inst[25:0], 2'b00});
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
         6'h08, 6'h09, 6'h0A, 6'h0B:
            d_imm = {{(W-16){h_inst[15]}}, h_inst[15:0]};
         6'h0C, 6'h0D, 6'h0E:
            d_imm = W'(h_inst[15:0]);
         6'h04, 6'h05, 6'h06, 6'h07, 6'h01:
            d_imm = {{(W-18){h_inst[15]}}, h_inst[15:0], 2'b00};
         6'h0F:
            d_imm = W'({h_inst[15:0], 16'h0000});
         default: begin
            d_imm = '0;
`ifdef ID_ILLEGAL_DET_EN
            d_known = 1'b0;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_pc    <= '0;
         bus.inst_type <= '0;
         bus.op_code   <= '0;
         bus.funct     <= '0;
         bus.rs        <= '0;
         bus.rt        <= '0;
         bus.rd        <= '0;
         bus.shamt     <= '0;
         bus.imm       <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
      end else if (pop) begin
         bus.out_valid <= 1'b1;
         bus.out_pc    <= h_pc;
         bus.inst_type <= d_type;
         bus.op_code   <= d_op;
         bus.funct     <= d_funct;
         bus.rs        <= h_inst[25:21];
         bus.rt        <= h_inst[20:16];
         bus.rd        <= h_inst[15:11];
         bus.shamt     <= h_inst[10:6];
         bus.imm       <= d_imm;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

`ifdef ID_ILLEGAL_DET_EN
   always_ff @(posedge clk) begin
      if (rst)
         bus.illegal <= 1'b0;
      else if (!flush && pop)
         bus.illegal <= !d_known;
   end
`else
   assign bus.illegal = 1'b0;
`endif
endmodule
